// File: rtl/timer_keypad_control.sv
// timer_keypad_control: keypad sync/debounce/encode with load strobe, plus gated 1 Hz timebase.
// Optional held-key auto-repeat is enabled by defining KEY_REPEAT_EN.
module timer_keypad_control #(
    parameter int NUM_KEYS        = 10,
    parameter int CODE_W          = 4,
    parameter int DIV_HALF        = 50,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int REPEAT_CYCLES   = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enablen,
    input  logic [NUM_KEYS-1:0] key,
    output logic [CODE_W-1:0]   D,
    output logic                loadn,
    output logic                key_valid,
    output logic                pgt_1Hz,
    output logic                pgt_tick
);
    localparam logic [1:0] IDLE = 2'd0, DEBOUNCE = 2'd1, LOAD = 2'd2, WAIT_RELEASE = 2'd3;
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = $clog2(DIV_HALF);

    if (2**CODE_W < NUM_KEYS || REPEAT_CYCLES < 1) begin : g_param_check
        $error("timer_keypad_control: CODE_W too narrow or REPEAT_CYCLES < 1");
    end

    logic [NUM_KEYS-1:0] sync1, sync2;
    logic [1:0]          state;
    logic [CODE_W-1:0]   cand, code;
    logic [DB_W-1:0]     cnt;
    logic [DIV_W-1:0]    dcnt;
    logic                any;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end

    // highest set index wins; key 0 is a real key, so "no key" is tracked by any
    always_comb begin
        code = '0;
        any  = |sync2;
        for (int i = 0; i < NUM_KEYS; i++)
            if (sync2[i]) code = CODE_W'(i);
    end

`ifdef KEY_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES);
    logic [REP_W-1:0] rcnt;
    logic             rep_hold, rep_fire;
    assign rep_hold = state == WAIT_RELEASE && any && code == D;
    assign rep_fire = rep_hold && loadn && rcnt == REP_W'(REPEAT_CYCLES - 1);
    // the strobe cycle itself does not count towards the next repeat
    always_ff @(posedge clk or posedge rst)
        if (rst) rcnt <= '0;
        else rcnt <= (!enablen || !rep_hold || !loadn || rep_fire) ? '0 : rcnt + 1'b1;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
            D     <= '0;
            loadn <= 1'b1;
        end else if (!enablen) begin
            state <= IDLE;
            cnt   <= '0;
            loadn <= 1'b1;
        end else begin
            loadn <= 1'b1;
            case (state)
                IDLE:
                    if (any) begin
                        state <= DEBOUNCE;
                        cand  <= code;
                        cnt   <= DB_W'(1);
                    end
                DEBOUNCE:
                    if (!any) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (code != cand) begin
                        cand <= code;
                        cnt  <= DB_W'(1);
                    end else if (cnt == DB_W'(DEBOUNCE_CYCLES)) begin
                        state <= LOAD;
                        loadn <= 1'b0;
                        D     <= cand;
                        cnt   <= '0;
                    end else cnt <= cnt + 1'b1;
                LOAD:
                    state <= WAIT_RELEASE;
                default: begin
`ifdef KEY_REPEAT_EN
                    if (rep_fire) loadn <= 1'b0;
`endif
                    if (any) cnt <= '0;
                    else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else cnt <= cnt + 1'b1;
                end
            endcase
        end

    assign key_valid = state == WAIT_RELEASE;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            dcnt     <= '0;
            pgt_1Hz  <= 1'b0;
            pgt_tick <= 1'b0;
        end else if (!enablen) begin
            dcnt     <= '0;
            pgt_1Hz  <= 1'b0;
            pgt_tick <= 1'b0;
        end else begin
            dcnt     <= dcnt == DIV_W'(DIV_HALF - 1) ? '0 : dcnt + 1'b1;
            pgt_1Hz  <= dcnt == DIV_W'(DIV_HALF - 1) ? !pgt_1Hz : pgt_1Hz;
            pgt_tick <= dcnt == DIV_W'(DIV_HALF - 1) && !pgt_1Hz;
        end
endmodule
